uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: the serial end of the CPU's outbound byte interface (DataIn / DataInValid / DataInReady).
- Accepts bytes from the datapath's store-to-UART path into a small FIFO.
- Serializes each byte as 8N1 (1 start, 8 data LSB-first, 1 stop) at a fixed baud rate.
- Lets software issue back-to-back transmit stores without polling for every byte.

Parameters:
- CLOCK_FREQ, 50_000_000, system clock in Hz.
- BAUD_RATE, 115_200, serial bit rate.
- FIFO_DEPTH, 8, FIFO entries; must be a power of 2, at least 2.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- DataIn  input  8  byte to transmit.
- DataInValid  input  1  producer has a byte this cycle.
- DataInReady  output  1  FIFO can accept a byte this cycle.
- SOut  output  1  serial line; idle high.
- Busy  output  1  frame in progress or FIFO non-empty.
- Count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Single clock domain (CLK). Reset is synchronous and active-high.
- Bit period N = CLOCK_FREQ / BAUD_RATE, integer division; the bit counter runs 0..N-1.
- Reset values, from the edge where reset=1: SOut=1, DataInReady=1, Busy=0, Count=0; FSM in IDLE; FIFO pointers at 0.
- Handshake:
  - A byte is enqueued on a rising edge where DataInValid && DataInReady.
  - DataInReady = (Count != FIFO_DEPTH). It is decoded from registered state only, with no combinational path from DataInValid.
  - DataInValid while DataInReady=0 has no effect; the byte is dropped, and the producer is responsible for holding or retrying.
- FIFO:
  - Circular buffer with read/write pointers wrapping at FIFO_DEPTH.
  - Push and pop on the same edge leave Count unchanged and preserve order.
  - A pop occurs only when Count != 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: SOut=1. If Count != 0, pop the head into the shift register and go to START on the same edge.
  - START: SOut=0 for N cycles, then go to DATA with bit index 0.
  - DATA: SOut=shift[0] for N cycles per bit; shift right after each bit. After bit 7 completes, go to STOP.
  - STOP: SOut=1 for N cycles. On the last cycle: if Count != 0, pop and go directly to START (no idle gap between frames); otherwise go to IDLE.
- SOut is registered, with no glitches.
- Latency:
  - A byte enqueued at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1.
  - SOut falls at edge k+1.
  - A frame is exactly 10*N cycles.
- Busy = (state != IDLE) || (Count != 0).
- Reset mid-frame: the frame is aborted and the FIFO is flushed. SOut is high from the reset edge onward. The next accepted byte starts a clean frame.
- A push into a full FIFO coinciding with a pop is not accepted, because DataInReady is already 0 that cycle.

Test Plan:
All scenarios use CLOCK_FREQ=1000, BAUD_RATE=100, so N=10.
1. Single byte: push 0xA5 at edge k -> SOut=0 for cycles k+1..k+10, then data bits 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles. Busy drops at edge k+101. Count returns to 0 at edge k+1.
2. Burst: DataInValid held high with bytes 0x00..0x09 on consecutive edges -> 9 bytes accepted (0x00 popped immediately). DataInReady=0 after the 9th accept, with Count=8. 0x09 is not accepted while Ready=0. Nine frames are emitted contiguously over 900 cycles with no idle gap.
3. Full FIFO: with Count=8, drive DataInValid=1, DataIn=0xFF for 5 cycles -> Count stays 8 and 0xFF never appears on SOut. At the first pop, DataInReady rises at the next cycle.
4. Push/pop collision: Count=3, push 0x3C on the same edge as a STOP-end pop -> Count stays 3. 0x3C is transmitted 4th after the current frame.
5. Reset mid-frame: assert reset for 1 cycle at the 35th cycle of a 0x5A frame with Count=2 -> SOut=1, Count=0, DataInReady=1, Busy=0 from that edge. Then push 0x81 -> a clean frame with data bits 1,0,0,0,0,0,0,1.
6. Edge data: push 0x00 then 0xFF -> start+8 zeros+stop, then start+8 ones+stop, 200 cycles total. SOut is exactly 1 between frames only during the stop bit.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeding a start/data/stop
// serializer. All outputs, including DataInReady and Busy, are registered.
module uart_tx_fifo #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [7:0]                    DataIn,
  input  logic                          DataInValid,
  output logic                          DataInReady,
  output logic                          SOut,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   Count
);

  localparam int unsigned N  = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  logic            push;
  logic            pop;
  logic            bit_done;
  logic            busy_nxt;
  logic [CW-1:0]   count_nxt;

  // Handshake and pop decode; Ready is a register, so push never loops back to it.
  always_comb begin
    bit_done  = (baud_cnt == BW'(N - 1));
    push      = DataInValid && DataInReady;
    pop       = (Count != '0) && ((state == IDLE) || ((state == STOP) && bit_done));
    count_nxt = Count + CW'(push) - CW'(pop);
    busy_nxt  = (count_nxt != '0) || pop ||
                ((state != IDLE) && !((state == STOP) && bit_done));
  end

  always_ff @(posedge CLK) begin
    if (!reset && push) mem[wr_ptr] <= DataIn;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      Count       <= '0;
      DataInReady <= 1'b1;
      Busy        <= 1'b0;
      SOut        <= 1'b1;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
    end else begin
      Count       <= count_nxt;
      DataInReady <= (count_nxt != CW'(FIFO_DEPTH));
      Busy        <= busy_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case (state)
        IDLE: begin
          SOut     <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            SOut  <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            SOut     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              SOut  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              SOut    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            // Back-to-back frames: reload straight into START with no idle bit.
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              SOut  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
